// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats and instruction field positions.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  localparam int unsigned OPC_LSB  = 0;
  localparam int unsigned OPC_MSB  = 6;
  localparam int unsigned RD_LSB   = 7;
  localparam int unsigned RD_MSB   = 11;
  localparam int unsigned F3_LSB   = 12;
  localparam int unsigned F3_MSB   = 14;
  localparam int unsigned RS1_LSB  = 15;
  localparam int unsigned RS1_MSB  = 19;
  localparam int unsigned RS2_LSB  = 20;
  localparam int unsigned RS2_MSB  = 24;
  localparam int unsigned F7B5_BIT = 30;

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator and RV32I opcode legality check.
// Also used by the branch unit, so it carries no pipeline state.
module imm_gen
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output imm_type_e       immType,
  output logic [XLEN-1:0] exImm,
  output logic            illegal
);

  logic [6:0] opc;
  logic       sgn;

  assign opc = instr[OPC_MSB:OPC_LSB];
  assign sgn = instr[31];

  always_comb begin
    immType = IMM_NONE;
    illegal = 1'b0;
    unique case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: immType = IMM_I;
      OPC_STORE:                                  immType = IMM_S;
      OPC_BRANCH:                                 immType = IMM_B;
      OPC_LUI, OPC_AUIPC:                         immType = IMM_U;
      OPC_JAL:                                    immType = IMM_J;
      OPC_OP, OPC_FENCE:                          immType = IMM_NONE;
      default:                                    illegal = 1'b1;
    endcase
  end

  // Every format keeps instr[31] as the sign, so all replicate it into the upper bits.
  always_comb begin
    exImm = '0;
    unique case (immType)
      IMM_I:   exImm = {{(XLEN-11){sgn}}, instr[30:20]};
      IMM_S:   exImm = {{(XLEN-11){sgn}}, instr[30:25], instr[11:7]};
      IMM_B:   exImm = {{(XLEN-12){sgn}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   exImm = {{(XLEN-31){sgn}}, instr[30:12], 12'b0};
      IMM_J:   exImm = {{(XLEN-20){sgn}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: exImm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RISC-V decode stage: holds an instruction in D1 while register_file data returns,
// bypasses writebacks that the registered read would miss, and presents a handshaked bundle.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instrIn,
  input  logic [XLEN-1:0] pcIn,
  input  logic            instrValid,
  output logic            instrReady,
  input  logic            flush,
  output logic [4:0]      readReg1,
  output logic [4:0]      readReg2,
  input  logic [XLEN-1:0] readData1,
  input  logic [XLEN-1:0] readData2,
  input  logic            wbEnable,
  input  logic [4:0]      wbReg,
  input  logic [XLEN-1:0] wbData,
  output logic            exValid,
  input  logic            exReady,
  output logic [XLEN-1:0] exPc,
  output logic [XLEN-1:0] exRs1Data,
  output logic [XLEN-1:0] exRs2Data,
  output logic [XLEN-1:0] exImm,
  output logic [4:0]      exRd,
  output logic [6:0]      exOpcode,
  output logic [2:0]      exFunct3,
  output logic            exFunct7b5,
  output logic            exIllegal
);

  logic            d1_valid;
  logic [31:0]     d1_instr;
  logic [XLEN-1:0] d1_pc;
  logic            byp1, byp2;
  logic [XLEN-1:0] byp1_data, byp2_data;

  logic            ex_advance, d1_advance, d1_hold, accept, transfer;
  logic [4:0]      d1_rs1, d1_rs2;
  logic            byp1_set, byp2_set;
  logic [XLEN-1:0] opnd1, opnd2;
  imm_type_e       imm_type;
  logic [XLEN-1:0] imm;
  logic            illegal;

  assign ex_advance = !exValid || exReady;
  assign d1_advance = !d1_valid || ex_advance;
  assign d1_hold    = d1_valid && !ex_advance;
  assign instrReady = d1_advance && !flush;
  assign accept     = instrValid && instrReady;
  assign transfer   = d1_valid && ex_advance && !flush;

  assign d1_rs1 = d1_instr[RS1_MSB:RS1_LSB];
  assign d1_rs2 = d1_instr[RS2_MSB:RS2_LSB];

  // While D1 is stuck, keep re-reading its registers so readData tracks the latest edge.
  assign readReg1 = d1_hold ? d1_rs1 : instrIn[RS1_MSB:RS1_LSB];
  assign readReg2 = d1_hold ? d1_rs2 : instrIn[RS2_MSB:RS2_LSB];

  // A write on the sampling edge is invisible to the registered read; remember it.
  assign byp1_set = wbEnable && (wbReg == readReg1) && (readReg1 != 5'd0);
  assign byp2_set = wbEnable && (wbReg == readReg2) && (readReg2 != 5'd0);

  always_comb begin
    opnd1 = readData1;
    if (d1_rs1 == 5'd0)                     opnd1 = '0;
    else if (wbEnable && (wbReg == d1_rs1)) opnd1 = wbData;
    else if (byp1)                          opnd1 = byp1_data;
  end

  always_comb begin
    opnd2 = readData2;
    if (d1_rs2 == 5'd0)                     opnd2 = '0;
    else if (wbEnable && (wbReg == d1_rs2)) opnd2 = wbData;
    else if (byp2)                          opnd2 = byp2_data;
  end

  imm_gen #(
    .XLEN(XLEN)
  ) u_imm_gen (
    .instr  (d1_instr),
    .immType(imm_type),
    .exImm  (imm),
    .illegal(illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1_valid  <= 1'b0;
      d1_instr  <= '0;
      d1_pc     <= '0;
      byp1      <= 1'b0;
      byp2      <= 1'b0;
      byp1_data <= '0;
      byp2_data <= '0;
    end else begin
      if (flush) begin
        d1_valid <= 1'b0;
      end else if (accept) begin
        d1_valid <= 1'b1;
        d1_instr <= instrIn;
        d1_pc    <= pcIn;
      end else if (d1_advance) begin
        d1_valid <= 1'b0;
      end
      if (accept || d1_hold) begin
        byp1 <= byp1_set;
        byp2 <= byp2_set;
        if (byp1_set) byp1_data <= wbData;
        if (byp2_set) byp2_data <= wbData;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exValid    <= 1'b0;
      exPc       <= RESET_PC;
      exRs1Data  <= '0;
      exRs2Data  <= '0;
      exImm      <= '0;
      exRd       <= '0;
      exOpcode   <= '0;
      exFunct3   <= '0;
      exFunct7b5 <= 1'b0;
      exIllegal  <= 1'b0;
    end else if (flush) begin
      exValid <= 1'b0;
    end else if (transfer) begin
      exValid    <= 1'b1;
      exPc       <= d1_pc;
      exRs1Data  <= opnd1;
      exRs2Data  <= opnd2;
      exImm      <= imm;
      exRd       <= d1_instr[RD_MSB:RD_LSB];
      exOpcode   <= d1_instr[OPC_MSB:OPC_LSB];
      exFunct3   <= d1_instr[F3_MSB:F3_LSB];
      exFunct7b5 <= d1_instr[F7B5_BIT];
      exIllegal  <= illegal;
    end else if (exReady) begin
      exValid <= 1'b0;
    end
  end

endmodule
